mem_arb: RTL and testbench

- Schedules the single DRAM controller port between the frame write engine and the display read engine.
- Grants the port to exactly one engine at a time: raises that engine's probe, waits for its done pulse, drains the command FIFO, then re-arbitrates.
- Drives arb_state, which the write engine qualifies cmd_en with (2'b10 = write owns port) and the read engine with 2'b01.
- Sits beside both engines in the video_mix memory subsystem, on cmd_clk.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_pick.sv | 26 ++
 rtl/mem_arb.sv | 165 ++++++++++++++++
 tb/tb_mem_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb shared definitions: port-owner state encodings seen by both
// engines, burst size, and the watchdog counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_RD    = 2'b01,
        ARB_WR    = 2'b10,
        ARB_DRAIN = 2'b11
    } arb_state_e;

    localparam int BRST_WORDS = 64;
    localparam int WDT_W      = 13;

endpackage

// File: rtl/arb_pick.sv
// Combinational selector for the next DRAM port owner, evaluated in IDLE.
// A pending write is forced once the read run has saturated.
module arb_pick (
    input  logic wr_req,
    input  logic rd_req,
    input  logic rd_urgent,
    input  logic rd_sat,
    input  logic last_rd,
    output logic pick_rd,
    output logic pick_wr
);

    always_comb begin
        pick_rd = 1'b0;
        pick_wr = 1'b0;
        priority case (1'b1)
            (wr_req && rd_sat):  pick_wr = 1'b1;
            rd_urgent:           pick_rd = 1'b1;
            (wr_req && last_rd): pick_wr = 1'b1;
            rd_req:              pick_rd = 1'b1;
            wr_req:              pick_wr = 1'b1;
            default:             ;
        endcase
    end

endmodule

// File: rtl/mem_arb.sv
// DRAM command port arbiter between frame write and display read engines.
// Define MEM_ARB_WDT_EN to add the grant watchdog and sticky wdt_err.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int RD_MAX_RUN = 4,
    parameter int GAP_CYC    = 2,
    parameter int WDT_CYC    = 4096
) (
    input  logic       cmd_clk,
    input  logic       mem_rst,
    input  logic       calib_done,
    input  logic       cmd_empty,
    input  logic       wr_req,
    input  logic       wr_done,
    input  logic       rd_req,
    input  logic       rd_urgent,
    input  logic       rd_done,
    output logic [1:0] arb_state,
    output logic       wr_probe,
    output logic       rd_probe,
    output logic       wdt_err,
    output logic [7:0] debug
);

    localparam int RUN_W = $clog2(RD_MAX_RUN + 1) + 1;
    localparam int GAP_W = $clog2(GAP_CYC) + 1;

    arb_state_e       state_q, state_d;
    logic             wr_probe_q, wr_probe_d;
    logic             rd_probe_q, rd_probe_d;
    logic [RUN_W-1:0] rd_run_q, rd_run_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             last_rd_q, last_rd_d;
    logic             wdt_err_q, wdt_err_d;
    logic [7:0]       debug_q, debug_d;
    logic             pick_rd, pick_wr, rd_sat;

`ifdef MEM_ARB_WDT_EN
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             wdt_to;
    assign wdt_to = (wdt_q == WDT_W'(WDT_CYC - 1));
`endif

    assign rd_sat = (rd_run_q == RUN_W'(RD_MAX_RUN));

    arb_pick u_pick (
        .wr_req    (wr_req),
        .rd_req    (rd_req),
        .rd_urgent (rd_urgent),
        .rd_sat    (rd_sat),
        .last_rd   (last_rd_q),
        .pick_rd   (pick_rd),
        .pick_wr   (pick_wr)
    );

    always_comb begin
        state_d    = state_q;
        wr_probe_d = wr_probe_q;
        rd_probe_d = rd_probe_q;
        rd_run_d   = rd_run_q;
        gap_d      = gap_q;
        last_rd_d  = last_rd_q;
        wdt_err_d  = wdt_err_q;
`ifdef MEM_ARB_WDT_EN
        wdt_d      = wdt_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
`ifdef MEM_ARB_WDT_EN
                wdt_d = '0;
`endif
                if (calib_done && pick_rd) begin
                    state_d    = ARB_RD;
                    rd_probe_d = 1'b1;
                end else if (calib_done && pick_wr) begin
                    state_d    = ARB_WR;
                    wr_probe_d = 1'b1;
                end
            end
            ARB_RD: begin
                if (rd_done) begin
                    rd_probe_d = 1'b0;
                    state_d    = ARB_DRAIN;
                    gap_d      = GAP_W'(GAP_CYC - 1);
                    last_rd_d  = 1'b1;
                    if (!rd_sat) rd_run_d = rd_run_q + 1'b1;
                end
`ifdef MEM_ARB_WDT_EN
                else if (wdt_to) begin
                    rd_probe_d = 1'b0;
                    state_d    = ARB_DRAIN;
                    gap_d      = GAP_W'(GAP_CYC - 1);
                    wdt_err_d  = 1'b1;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
`endif
            end
            ARB_WR: begin
                if (wr_done) begin
                    wr_probe_d = 1'b0;
                    state_d    = ARB_DRAIN;
                    gap_d      = GAP_W'(GAP_CYC - 1);
                    last_rd_d  = 1'b0;
                    rd_run_d   = '0;
                end
`ifdef MEM_ARB_WDT_EN
                else if (wdt_to) begin
                    wr_probe_d = 1'b0;
                    state_d    = ARB_DRAIN;
                    gap_d      = GAP_W'(GAP_CYC - 1);
                    wdt_err_d  = 1'b1;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
`endif
            end
            ARB_DRAIN: begin
                // done levels are deliberately not looked at here
                if (gap_q != '0) gap_d = gap_q - 1'b1;
                else if (cmd_empty) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        debug_d = {wdt_err_d, rd_urgent, wr_req, rd_req,
                   rd_run_d[1:0], state_d};
    end

    always_ff @(posedge cmd_clk) begin
        if (mem_rst) begin
            state_q    <= ARB_IDLE;
            wr_probe_q <= 1'b0;
            rd_probe_q <= 1'b0;
            rd_run_q   <= '0;
            gap_q      <= '0;
            last_rd_q  <= 1'b0;
            wdt_err_q  <= 1'b0;
            debug_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_probe_q <= wr_probe_d;
            rd_probe_q <= rd_probe_d;
            rd_run_q   <= rd_run_d;
            gap_q      <= gap_d;
            last_rd_q  <= last_rd_d;
            wdt_err_q  <= wdt_err_d;
            debug_q    <= debug_d;
        end
    end

`ifdef MEM_ARB_WDT_EN
    always_ff @(posedge cmd_clk) begin
        if (mem_rst) wdt_q <= '0;
        else         wdt_q <= wdt_d;
    end
`endif

    assign arb_state = state_q;
    assign wr_probe  = wr_probe_q;
    assign rd_probe  = rd_probe_q;
    assign wdt_err   = wdt_err_q;
    assign debug     = debug_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized
// request rounds checked against a grant-level reference model.
module tb_mem_arb;

    localparam int RD_MAX = 4;
    localparam int GAP    = 2;
    localparam int WDT    = 16;

    logic       cmd_clk = 1'b0;
    logic       mem_rst, calib_done, cmd_empty;
    logic       wr_req, wr_done, rd_req, rd_urgent, rd_done;
    logic [1:0] arb_state;
    logic       wr_probe, rd_probe, wdt_err;
    logic [7:0] debug;

    int n_cmp = 0;
    int n_bad = 0;
    int m_run;
    bit m_last_rd;

    mem_arb #(.RD_MAX_RUN(RD_MAX), .GAP_CYC(GAP), .WDT_CYC(WDT)) dut (
        .cmd_clk(cmd_clk), .mem_rst(mem_rst), .calib_done(calib_done),
        .cmd_empty(cmd_empty), .wr_req(wr_req), .wr_done(wr_done),
        .rd_req(rd_req), .rd_urgent(rd_urgent), .rd_done(rd_done),
        .arb_state(arb_state), .wr_probe(wr_probe), .rd_probe(rd_probe),
        .wdt_err(wdt_err), .debug(debug)
    );

    always #5 cmd_clk = ~cmd_clk;

    task automatic tick();
        @(posedge cmd_clk);
        #1;
    endtask

    // 0 = no grant, 1 = read, 2 = write
    function automatic int exp_grant(bit wr, bit rd, bit urg, int run, bit lrd);
        if (wr && run >= RD_MAX) return 2;
        if (urg) return 1;
        if (wr && lrd) return 2;
        if (rd) return 1;
        if (wr) return 2;
        return 0;
    endfunction

    function automatic void model_update(int g);
        if (g == 1) begin
            m_run = (m_run < RD_MAX) ? m_run + 1 : RD_MAX;
            m_last_rd = 1'b1;
        end else if (g == 2) begin
            m_run = 0;
            m_last_rd = 1'b0;
        end
    endfunction

    task automatic reset_dut();
        mem_rst = 1'b1;
        calib_done = 1'b0; cmd_empty = 1'b1;
        wr_req = 1'b0; wr_done = 1'b0;
        rd_req = 1'b0; rd_urgent = 1'b0; rd_done = 1'b0;
        tick();
        tick();
        mem_rst = 1'b0;
        m_run = 0;
        m_last_rd = 1'b0;
    endtask

    // One IDLE->grant->DRAIN->IDLE round; returns observations only.
    task automatic run_grant(input bit wr, input bit rd, input bit urg,
                             input int hold, input int edly,
                             output int got, output int dwell,
                             output int fin, output bit pok,
                             output logic [7:0] dbg);
        pok = 1'b1; dwell = 0;
        wr_req = wr; rd_req = rd; rd_urgent = urg; cmd_empty = 1'b1;
        tick();
        got = int'(arb_state);
        fin = got;
        dbg = debug;
        pok = (rd_probe === (got == 1)) && (wr_probe === (got == 2));
        if (got == 1 || got == 2) begin
            for (int i = 0; i < hold; i++) begin
                if (got == 1) wr_done = 1'b1; else rd_done = 1'b1;
                wr_req = 1'($urandom_range(0, 1));
                rd_req = 1'($urandom_range(0, 1));
                rd_urgent = 1'b0;
                tick();
                if (int'(arb_state) != got || rd_probe !== (got == 1) ||
                    wr_probe !== (got == 2)) pok = 1'b0;
            end
            wr_done = (got == 2); rd_done = (got == 1);
            wr_req = 1'b0; rd_req = 1'b0; cmd_empty = 1'b0;
            tick();
            for (int o = 0; o < 64 && arb_state === 2'b11; o++) begin
                dwell++;
                if (rd_probe || wr_probe) pok = 1'b0;
                if (o >= 1) begin wr_done = 1'b0; rd_done = 1'b0; end
                cmd_empty = (o >= edly);
                tick();
            end
            fin = int'(arb_state);
        end
        wr_req = 1'b0; rd_req = 1'b0; rd_urgent = 1'b0;
        wr_done = 1'b0; rd_done = 1'b0; cmd_empty = 1'b1;
    endtask

    function automatic int exp_dwell(int g, int edly);
        if (g == 0) return 0;
        return (GAP > edly + 1) ? GAP : edly + 1;
    endfunction

    task automatic test_reset();
        mem_rst = 1'b1;
        calib_done = 1'b1; cmd_empty = 1'b1;
        wr_req = 1'b1; rd_req = 1'b1; rd_urgent = 1'b1;
        wr_done = 1'b0; rd_done = 1'b0;
        tick(); tick();
        n_cmp++;
        if (arb_state !== 2'b00 || wr_probe !== 1'b0 || rd_probe !== 1'b0 ||
            wdt_err !== 1'b0 || debug !== 8'h00) begin
            n_bad++;
            $display("FAIL reset: state=%b wp=%b rp=%b wdt=%b dbg=%h want 00/0/0/0/00",
                     arb_state, wr_probe, rd_probe, wdt_err, debug);
        end
        reset_dut();
    endtask

    task automatic test_calib_low();
        int bad = 0;
        reset_dut();
        calib_done = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (arb_state !== 2'b00 || wr_probe || rd_probe) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL calib_low: %0d cycles granted, want 0", bad);
        end
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_write_single();
        int entries = 0, drains = 0, probes = 0;
        logic [1:0] prev;
        reset_dut();
        calib_done = 1'b1; wr_req = 1'b1;
        tick();
        n_cmp++;
        if (arb_state !== 2'b10 || wr_probe !== 1'b1 || rd_probe !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_latency: state=%b wp=%b rp=%b want 10/1/0",
                     arb_state, wr_probe, rd_probe);
        end
        wr_req = 1'b0;
        tick(); tick();
        n_cmp++;
        if (arb_state !== 2'b10 || wr_probe !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_hold: state=%b wp=%b want 10/1", arb_state, wr_probe);
        end
        prev = arb_state;
        wr_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) wr_done = 1'b0;
            tick();
            if (arb_state === 2'b11 && prev !== 2'b11) entries++;
            if (arb_state === 2'b11) drains++;
            if (wr_probe || rd_probe) probes++;
            prev = arb_state;
        end
        n_cmp++;
        if (entries != 1 || drains != GAP || probes != 0 || arb_state !== 2'b00) begin
            n_bad++;
            $display("FAIL wr_done_level: entries=%0d drain=%0d probes=%0d end=%b want 1/%0d/0/00",
                     entries, drains, probes, arb_state, GAP);
        end
    endtask

    task automatic test_alternate();
        int got, dw, fin, e;
        bit pok;
        logic [7:0] dbg;
        reset_dut();
        calib_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = exp_grant(1, 1, 0, m_run, m_last_rd);
            run_grant(1, 1, 0, $urandom_range(0, 3), 0, got, dw, fin, pok, dbg);
            n_cmp++;
            if (got != e || !pok || dw != GAP || fin != 0) begin
                n_bad++;
                $display("FAIL alternate[%0d]: grant=%0d dwell=%0d end=%0d pok=%0d want %0d/%0d/0/1",
                         k, got, dw, fin, pok, e, GAP);
            end
            model_update(e);
        end
    endtask

    task automatic test_urgent();
        int got, dw, fin, e;
        bit pok;
        logic [7:0] dbg;
        reset_dut();
        calib_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            e = exp_grant(1, 1, 1, m_run, m_last_rd);
            run_grant(1, 1, 1, $urandom_range(0, 2), 0, got, dw, fin, pok, dbg);
            n_cmp++;
            if (got != e || !pok || dbg[3:2] !== 2'(m_run)) begin
                n_bad++;
                $display("FAIL urgent[%0d]: grant=%0d run=%0d pok=%0d want %0d/%0d/1",
                         k, got, dbg[3:2], pok, e, m_run % 4);
            end
            model_update(e);
        end
    endtask

    task automatic test_drain_hold();
        int got, dw, fin;
        bit pok;
        logic [7:0] dbg;
        reset_dut();
        calib_done = 1'b1;
        run_grant(0, 1, 0, 1, 12, got, dw, fin, pok, dbg);
        n_cmp++;
        if (got != 1 || dw != exp_dwell(1, 12) || fin != 0 || !pok) begin
            n_bad++;
            $display("FAIL drain_hold: grant=%0d dwell=%0d end=%0d want 1/%0d/0",
                     got, dw, fin, exp_dwell(1, 12));
        end
    endtask

    task automatic test_random();
        int got, dw, fin, e, ed, hd;
        bit pok, w, r, u;
        logic [7:0] dbg;
        reset_dut();
        calib_done = 1'b1;
        for (int k = 0; k < 40; k++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            u = ($urandom_range(0, 3) == 0);
            r = r | u;
            hd = $urandom_range(0, 4);
            ed = $urandom_range(0, 4);
            e = exp_grant(w, r, u, m_run, m_last_rd);
            run_grant(w, r, u, hd, ed, got, dw, fin, pok, dbg);
            n_cmp++;
            if (got != e || dw != exp_dwell(e, ed) || fin != 0 || !pok) begin
                n_bad++;
                $display("FAIL random[%0d]: grant=%0d dwell=%0d end=%0d pok=%0d want %0d/%0d/0/1",
                         k, got, dw, fin, pok, e, exp_dwell(e, ed));
            end
            n_cmp++;
            if (dbg !== {1'b0, u, w, r, 2'(m_run), 2'(e)}) begin
                n_bad++;
                $display("FAIL random_dbg[%0d]: debug=%h want %h", k, dbg,
                         {1'b0, u, w, r, 2'(m_run), 2'(e)});
            end
            model_update(e);
        end
    endtask

    task automatic test_calib_drop();
        int bad = 0;
        reset_dut();
        calib_done = 1'b1; rd_req = 1'b1;
        tick();
        calib_done = 1'b0;
        tick(); tick();
        n_cmp++;
        if (arb_state !== 2'b01 || rd_probe !== 1'b1) begin
            n_bad++;
            $display("FAIL calib_drop_hold: state=%b rp=%b want 01/1", arb_state, rd_probe);
        end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0; wr_req = 1'b1;
        for (int i = 0; i < 20 && arb_state !== 2'b00; i++) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (arb_state !== 2'b00 || wr_probe || rd_probe) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL calib_drop_regrant: %0d bad cycles want 0", bad);
        end
        wr_req = 1'b0; rd_req = 1'b0; calib_done = 1'b1;
    endtask

    task automatic test_reset_mid();
        reset_dut();
        calib_done = 1'b1; wr_req = 1'b1;
        tick();
        wr_req = 1'b0; mem_rst = 1'b1;
        tick();
        mem_rst = 1'b0;
        n_cmp++;
        if (arb_state !== 2'b00 || wr_probe !== 1'b0 || rd_probe !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: state=%b wp=%b rp=%b want 00/0/0",
                     arb_state, wr_probe, rd_probe);
        end
    endtask

`ifdef MEM_ARB_WDT_EN
    task automatic test_wdt();
        int n = 0;
        reset_dut();
        calib_done = 1'b1; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        while (arb_state === 2'b10 && n < WDT + 20) begin
            n++;
            tick();
        end
        n_cmp++;
        if (n != WDT || arb_state !== 2'b11 || wr_probe !== 1'b0 || wdt_err !== 1'b1) begin
            n_bad++;
            $display("FAIL wdt_timeout: cycles=%0d state=%b wp=%b err=%b want %0d/11/0/1",
                     n, arb_state, wr_probe, wdt_err, WDT);
        end
        for (int i = 0; i < 30; i++) tick();
        n_cmp++;
        if (wdt_err !== 1'b1) begin
            n_bad++;
            $display("FAIL wdt_sticky: err=%b want 1", wdt_err);
        end
        reset_dut();
        n_cmp++;
        if (wdt_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wdt_clear: err=%b want 0", wdt_err);
        end
    endtask
`else
    task automatic test_wdt();
        reset_dut();
        calib_done = 1'b1; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < WDT + 10; i++) tick();
        n_cmp++;
        if (arb_state !== 2'b10 || wr_probe !== 1'b1 || wdt_err !== 1'b0) begin
            n_bad++;
            $display("FAIL no_wdt: state=%b wp=%b err=%b want 10/1/0",
                     arb_state, wr_probe, wdt_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_calib_low();
        test_write_single();
        test_alternate();
        test_urgent();
        test_drain_hold();
        test_random();
        test_calib_drop();
        test_reset_mid();
        test_wdt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
